// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache data-array controller.
// Contents: the controller state enum, the byte-mask width derivation and the
// word-level byte-merge function, used for read-modify-write stores.
package dcache_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  localparam int DCACHE_DWIDTH = 32;
  localparam int DCACHE_AWIDTH = 8;

  // One mask bit per byte lane.
  function automatic int mwidth_of(input int dwidth);
    return dwidth / 8;
  endfunction

  localparam int DCACHE_MWIDTH = mwidth_of(DCACHE_DWIDTH);

  typedef logic [DCACHE_DWIDTH-1:0] word_t;
  typedef logic [DCACHE_MWIDTH-1:0] mask_t;

  function automatic logic [7:0] merge_byte(input logic       sel,
                                            input logic [7:0] new_byte,
                                            input logic [7:0] old_byte);
    return sel ? new_byte : old_byte;
  endfunction

  // Lanes with a set mask bit take the new word, the rest keep the old word.
  function automatic word_t byte_merge(input mask_t mask,
                                       input word_t new_word,
                                       input word_t old_word);
    word_t merged;
    merged = '0;
    for (int b = 0; b < DCACHE_MWIDTH; b++) begin
      merged[b*8 +: 8] = merge_byte(mask[b], new_word[b*8 +: 8], old_word[b*8 +: 8]);
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_data_ctrl_if.sv
// Bundle of the CPU request/response, mem request/response and both RAM port
// signals of the dcache data controller.
// Modports: slave = controller view, master = environment (CPU, mem engine, RAM).
interface dcache_data_ctrl_if
  import dcache_pkg::*;
#(
  parameter int DWIDTH = DCACHE_DWIDTH,
  parameter int AWIDTH = DCACHE_AWIDTH
) ();

  localparam int MWIDTH = mwidth_of(DWIDTH);

  // CPU side
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [AWIDTH-1:0] cpu_addr;
  logic              cpu_we;
  logic [MWIDTH-1:0] cpu_wmask;
  logic [DWIDTH-1:0] cpu_wdata;
  logic              cpu_resp_valid;
  logic [DWIDTH-1:0] cpu_rdata;

  // refill / writeback side
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;

  // data RAM, both ports synchronous read with one cycle latency
  logic [AWIDTH-1:0] ram_addr0;
  logic [DWIDTH-1:0] ram_d0;
  logic              ram_we0;
  logic [DWIDTH-1:0] ram_q0;
  logic [AWIDTH-1:0] ram_addr1;
  logic [DWIDTH-1:0] ram_d1;
  logic              ram_we1;
  logic [DWIDTH-1:0] ram_q1;

  modport slave (
    input  cpu_req_valid, cpu_addr, cpu_we, cpu_wmask, cpu_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata,
    output ram_addr0, ram_d0, ram_we0,
    input  ram_q0,
    output ram_addr1, ram_d1, ram_we1,
    input  ram_q1
  );

  modport master (
    output cpu_req_valid, cpu_addr, cpu_we, cpu_wmask, cpu_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    input  ram_addr0, ram_d0, ram_we0,
    output ram_q0,
    input  ram_addr1, ram_d1, ram_we1,
    output ram_q1
  );

endinterface

// File: rtl/dcache_byte_merge.sv
// Purpose: combinational byte-lane merge of a store word into an old word.
// Latency: 0 cycles.
// Backpressure: none (pure combinational).
// Ports: mask (per-byte select), new_word, old_word in; merged_word out.
module dcache_byte_merge
  import dcache_pkg::*;
#(
  parameter  int DWIDTH = DCACHE_DWIDTH,
  localparam int MWIDTH = mwidth_of(DWIDTH)
) (
  input  logic [MWIDTH-1:0] mask,
  input  logic [DWIDTH-1:0] new_word,
  input  logic [DWIDTH-1:0] old_word,
  output logic [DWIDTH-1:0] merged_word
);

  // The package word function is fixed to the default width; other widths
  // fall back to a per-lane build from the same byte helper.
  if (DWIDTH == DCACHE_DWIDTH) begin : g_word
    assign merged_word = byte_merge(mask, new_word, old_word);
  end else begin : g_lane
    for (genvar b = 0; b < MWIDTH; b++) begin : g_byte
      assign merged_word[b*8 +: 8] =
        merge_byte(mask[b], new_word[b*8 +: 8], old_word[b*8 +: 8]);
    end
  end

endmodule

// File: rtl/dcache_data_ctrl.sv
// Purpose: sequences the 2-port dcache data RAM; RMW for partial stores, refill side wins same-word conflicts.
// Latency: load/store response and mem read data 1 cycle after accept; partial store blocks CPU for 1 extra cycle.
// Backpressure: cpu_req_ready drops in MERGE or on a same-word conflict; mem_req_ready drops only for the RMW word in MERGE; responses are never stalled.
// Ports: clk, rst (async active-high), bus (dcache_data_ctrl_if.slave: CPU req/resp, mem req/resp, RAM ports 0 and 1).
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter  int DWIDTH = DCACHE_DWIDTH,
  parameter  int AWIDTH = DCACHE_AWIDTH,
  localparam int MWIDTH = mwidth_of(DWIDTH)
) (
  input logic               clk,
  input logic               rst,
  dcache_data_ctrl_if.slave bus
);

  localparam logic [MWIDTH-1:0] MASK_FULL = '1;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [MWIDTH-1:0] pend_mask_q, pend_mask_d;
  logic [DWIDTH-1:0] pend_data_q, pend_data_d;
  logic              cpu_resp_q, cpu_resp_d;   // response owed for a non-RMW request
  logic              cpu_load_q, cpu_load_d;   // that response carries port 0 read data
  logic              mem_rd_q, mem_rd_d;

  logic              hazard_idle;
  logic              merge_block;
  logic              cpu_rdy;
  logic              mem_rdy;
  logic              cpu_acc;
  logic              mem_acc;
  logic              cpu_full;
  logic              cpu_partial;
  logic [DWIDTH-1:0] merged_word;

  dcache_byte_merge #(.DWIDTH(DWIDTH)) u_merge (
    .mask        (pend_mask_q),
    .new_word    (pend_data_q),
    .old_word    (bus.ram_q0),
    .merged_word (merged_word)
  );

  // Request decode and arbitration.
  always_comb begin
    hazard_idle = bus.cpu_req_valid && bus.mem_req_valid &&
                  (bus.cpu_addr == bus.mem_addr) && (bus.cpu_we || bus.mem_we);
    // In MERGE, port 0 writes the pending word, so any mem access to it must wait.
    merge_block = (state_q == ST_MERGE) && (bus.mem_addr == pend_addr_q);
    cpu_rdy     = !rst && (state_q == ST_IDLE) && !hazard_idle;
    mem_rdy     = !rst && !merge_block;
    cpu_acc     = bus.cpu_req_valid && cpu_rdy;
    mem_acc     = bus.mem_req_valid && mem_rdy;
    cpu_full    = bus.cpu_we && (bus.cpu_wmask == MASK_FULL);
    cpu_partial = bus.cpu_we && (bus.cpu_wmask != '0) && (bus.cpu_wmask != MASK_FULL);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= '0;
      pend_mask_q <= '0;
      pend_data_q <= '0;
      cpu_resp_q  <= 1'b0;
      cpu_load_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_mask_q <= pend_mask_d;
      pend_data_q <= pend_data_d;
      cpu_resp_q  <= cpu_resp_d;
      cpu_load_q  <= cpu_load_d;
      mem_rd_q    <= mem_rd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_mask_d = pend_mask_q;
    pend_data_d = pend_data_q;
    cpu_resp_d  = 1'b0;
    cpu_load_d  = 1'b0;
    mem_rd_d    = mem_acc && !bus.mem_we;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_acc) begin
          // The RMW response comes from MERGE itself, not from cpu_resp_q.
          cpu_resp_d = !cpu_partial;
          cpu_load_d = !bus.cpu_we;
          if (cpu_partial) begin
            state_d     = ST_MERGE;
            pend_addr_d = bus.cpu_addr;
            pend_mask_d = bus.cpu_wmask;
            pend_data_d = bus.cpu_wdata;
          end
        end
      end
      ST_MERGE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; everything is forced to zero while rst is high.
  always_comb begin
    bus.cpu_req_ready  = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_rdata      = '0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    bus.ram_addr0      = '0;
    bus.ram_d0         = '0;
    bus.ram_we0        = 1'b0;
    bus.ram_addr1      = '0;
    bus.ram_d1         = '0;
    bus.ram_we1        = 1'b0;
    if (!rst) begin
      bus.cpu_req_ready  = cpu_rdy;
      bus.mem_req_ready  = mem_rdy;
      bus.cpu_resp_valid = cpu_resp_q || (state_q == ST_MERGE);
      bus.cpu_rdata      = cpu_load_q ? bus.ram_q0 : '0;
      bus.mem_rvalid     = mem_rd_q;
      bus.mem_rdata      = mem_rd_q ? bus.ram_q1 : '0;

      if (mem_acc) begin
        bus.ram_addr1 = bus.mem_addr;
        bus.ram_we1   = bus.mem_we;
        bus.ram_d1    = bus.mem_we ? bus.mem_wdata : '0;
      end

      // An unused port 0 is parked on a word port 1 is not touching.
      bus.ram_addr0 = bus.ram_addr1 ^ AWIDTH'(1);
      if (state_q == ST_MERGE) begin
        bus.ram_addr0 = pend_addr_q;
        bus.ram_d0    = merged_word;
        bus.ram_we0   = 1'b1;
      end else if (cpu_acc) begin
        // Loads, partial-store reads and zero-mask stores only read.
        bus.ram_addr0 = bus.cpu_addr;
        if (cpu_full) begin
          bus.ram_d0  = bus.cpu_wdata;
          bus.ram_we0 = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
module tb_dcache_data_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          due;
  } cpu_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ram     [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_data_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  dcache_data_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 2-port synchronous-read RAM.
  always @(posedge clk) begin
    if (bus.ram_we0) ram[bus.ram_addr0] <= bus.ram_d0;
    if (bus.ram_we1) ram[bus.ram_addr1] <= bus.ram_d1;
    bus.ram_q0 <= ram[bus.ram_addr0];
    bus.ram_q1 <= ram[bus.ram_addr1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Response scoreboard: every pending entry must be answered in its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        check("cpu_resp_valid", 32'(bus.cpu_resp_valid), 1);
        if (e.is_load) check("cpu_rdata", bus.cpu_rdata, e.data);
      end else if (bus.cpu_resp_valid) begin
        check("cpu_resp_spurious", 32'(bus.cpu_resp_valid), 0);
      end
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        mem_exp_t m;
        m = mem_q.pop_front();
        check("mem_rvalid", 32'(bus.mem_rvalid), 1);
        check("mem_rdata", bus.mem_rdata, m.data);
      end else if (bus.mem_rvalid) begin
        check("mem_rvalid_spurious", 32'(bus.mem_rvalid), 0);
      end
    end
  end

  task automatic model_cpu(input logic [7:0] a, input bit we, input logic [3:0] m,
                           input logic [31:0] d);
    cpu_exp_t e;
    e.is_load = !we;
    e.data    = ref_mem[a];
    e.due     = cyc + 1;
    cpu_q.push_back(e);
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic model_mem(input logic [7:0] a, input bit we, input logic [31:0] d);
    mem_exp_t e;
    if (we) begin
      ref_mem[a] = d;
    end else begin
      e.data = ref_mem[a];
      e.due  = cyc + 1;
      mem_q.push_back(e);
    end
  endtask

  // Drives a CPU and/or mem request from just after a rising edge and holds
  // each until accepted; returns the acceptance cycle of each side.
  task automatic issue(input bit c_en, input logic [7:0] c_addr, input bit c_we,
                       input logic [3:0] c_mask, input logic [31:0] c_data,
                       input bit m_en, input logic [7:0] m_addr, input bit m_we,
                       input logic [31:0] m_data, output int c_acc, output int m_acc);
    bit c_pend;
    bit m_pend;
    c_pend = c_en;
    m_pend = m_en;
    c_acc  = -1;
    m_acc  = -1;
    bus.cpu_addr = c_addr; bus.cpu_we = c_we; bus.cpu_wmask = c_mask; bus.cpu_wdata = c_data;
    bus.mem_addr = m_addr; bus.mem_we = m_we; bus.mem_wdata = m_data;
    bus.cpu_req_valid = c_pend;
    bus.mem_req_valid = m_pend;
    for (int i = 0; i < 16 && (c_pend || m_pend); i++) begin
      @(negedge clk);
      if (m_pend && bus.mem_req_ready) begin
        m_acc = cyc;
        model_mem(m_addr, m_we, m_data);
        m_pend = 1'b0;
      end
      if (c_pend && bus.cpu_req_ready) begin
        c_acc = cyc;
        model_cpu(c_addr, c_we, c_mask, c_data);
        c_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.cpu_req_valid = c_pend;
      bus.mem_req_valid = m_pend;
    end
    if (c_pend) check("cpu_accept_timeout", 32'(c_pend), 0);
    if (m_pend) check("mem_accept_timeout", 32'(m_pend), 0);
    bus.cpu_req_valid = 1'b0;
    bus.mem_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int ca, ma, ca2, ma2;
    logic [31:0] saved;
    logic [7:0]  addr_list [0:4];

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    // Requests held active during reset must all be ignored.
    bus.cpu_req_valid = 1'b1; bus.cpu_addr = 8'h05; bus.cpu_we = 1'b1;
    bus.cpu_wmask = 4'hF; bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.mem_req_valid = 1'b1; bus.mem_addr = 8'h06; bus.mem_we = 1'b1;
    bus.mem_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_cpu_req_ready", 32'(bus.cpu_req_ready), 0);
    check("rst_mem_req_ready", 32'(bus.mem_req_ready), 0);
    check("rst_cpu_resp_valid", 32'(bus.cpu_resp_valid), 0);
    check("rst_mem_rvalid", 32'(bus.mem_rvalid), 0);
    check("rst_ram_we0", 32'(bus.ram_we0), 0);
    check("rst_ram_we1", 32'(bus.ram_we1), 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    bus.mem_req_valid = 1'b0;
    rst = 1'b0;

    // Preload through the mem write path.
    issue(0, 0, 0, 0, 0, 1, 8'h05, 1, 32'hDEAD_BEEF, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h06, 1, 32'hCAFE_F00D, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h10, 1, 32'h0000_0000, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h20, 1, 32'h0102_0304, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h30, 1, 32'h1234_5678, ca, ma);

    // Plain load.
    issue(1, 8'h05, 0, 4'h0, 0, 0, 0, 0, 0, ca, ma);

    // Partial store then an immediate load: CPU blocked for the MERGE cycle.
    issue(1, 8'h05, 1, 4'b0010, 32'h0000_AB00, 0, 0, 0, 0, ca, ma);
    issue(1, 8'h05, 0, 4'h0, 0, 0, 0, 0, 0, ca2, ma);
    check("rmw_load_gap", ca2 - ca, 2);

    // Same-word mem write and CPU load: mem first, CPU retried next cycle.
    issue(1, 8'h10, 0, 4'h0, 0, 1, 8'h10, 1, 32'h1111_1111, ca, ma);
    check("conflict_cpu_stall", ca - ma, 1);

    // mem read of the RMW word during MERGE waits one cycle.
    issue(1, 8'h05, 1, 4'b1000, 32'h5A00_0000, 0, 0, 0, 0, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h05, 0, 0, ca2, ma2);
    check("merge_block_gap", ma2 - ca, 2);
    // mem read of another word during MERGE goes straight through.
    issue(1, 8'h05, 1, 4'b0100, 32'h0033_0000, 0, 0, 0, 0, ca, ma);
    issue(0, 0, 0, 0, 0, 1, 8'h06, 0, 0, ca2, ma2);
    check("merge_other_gap", ma2 - ca, 1);

    // Full store and mem read to different words in one cycle.
    issue(1, 8'h20, 1, 4'hF, 32'hA5A5_A5A5, 1, 8'h05, 0, 0, ca, ma);
    check("full_store_mem_read_same_cycle", ca - ma, 0);
    issue(1, 8'h20, 0, 4'h0, 0, 0, 0, 0, 0, ca2, ma2);
    check("full_store_load_gap", ca2 - ca, 1);

    // Two reads of one word proceed together.
    issue(1, 8'h06, 0, 4'h0, 0, 1, 8'h06, 0, 0, ca, ma);
    check("dual_read_same_cycle", ca - ma, 0);

    // Zero-mask store: response only, word unchanged.
    issue(1, 8'h06, 1, 4'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, ca, ma);
    issue(1, 8'h06, 0, 4'h0, 0, 0, 0, 0, 0, ca2, ma2);
    check("zero_mask_load_gap", ca2 - ca, 1);

    // Reset in the MERGE cycle aborts the RMW.
    saved = ref_mem[8'h30];
    issue(1, 8'h30, 1, 4'b0001, 32'h0000_00FF, 0, 0, 0, 0, ca, ma);
    rst = 1'b1;
    bus.mem_req_valid = 1'b1; bus.mem_addr = 8'h31; bus.mem_we = 1'b0;
    @(negedge clk);
    check("abort_cpu_resp_valid", 32'(bus.cpu_resp_valid), 0);
    check("abort_ram_we0", 32'(bus.ram_we0), 0);
    check("abort_cpu_req_ready", 32'(bus.cpu_req_ready), 0);
    check("abort_mem_req_ready", 32'(bus.mem_req_ready), 0);
    check("abort_mem_rvalid", 32'(bus.mem_rvalid), 0);
    check("abort_ram_we1", 32'(bus.ram_we1), 0);
    cpu_q.delete();
    ref_mem[8'h30] = saved;
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    rst = 1'b0;
    issue(1, 8'h30, 0, 4'h0, 0, 0, 0, 0, 0, ca, ma);

    repeat (3) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    addr_list[0] = 8'h05; addr_list[1] = 8'h06; addr_list[2] = 8'h10;
    addr_list[3] = 8'h20; addr_list[4] = 8'h30;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ram_word_%02h", addr_list[i]), ram[addr_list[i]], ref_mem[addr_list[i]]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
